// File: rtl/keypad_pkg.sv
// Shared state type and phone-style symbol map for the matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } kp_state_e;

    localparam logic [3:0] SN = 4'd0;
    localparam logic [3:0] SA = 4'd1;
    localparam logic [3:0] SS = 4'd2;
    localparam logic [3:0] S0 = 4'd3;
    localparam logic [3:0] S1 = 4'd4;
    localparam logic [3:0] S2 = 4'd5;
    localparam logic [3:0] S3 = 4'd6;
    localparam logic [3:0] S4 = 4'd7;
    localparam logic [3:0] S5 = 4'd8;
    localparam logic [3:0] S6 = 4'd9;
    localparam logic [3:0] S7 = 4'd10;
    localparam logic [3:0] S8 = 4'd11;
    localparam logic [3:0] S9 = 4'd12;

    function automatic logic [3:0] keypad_4x3_symbol(input logic [3:0] code);
        logic [3:0] sym;
        case (code)
            4'd0:    sym = S1;
            4'd1:    sym = S2;
            4'd2:    sym = S3;
            4'd3:    sym = S4;
            4'd4:    sym = S5;
            4'd5:    sym = S6;
            4'd6:    sym = S7;
            4'd7:    sym = S8;
            4'd8:    sym = S9;
            4'd9:    sym = SA;
            4'd10:   sym = S0;
            4'd11:   sym = SS;
            default: sym = SN;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Saturating count of consecutive clocks on which the watched level is stable.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic stable,
    output logic done
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart on clear or instability, saturate at the target.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !stable) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_MAX);

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot column strobing, press/release debounce,
// registered key index with single-cycle event strobes and auto-repeat.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 3,
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CYC = 8,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 16,
    parameter int CODE_W       = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROWS-1:0]   key_row,
    input  logic              repeat_en,
    output logic [COLS-1:0]   key_col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              key_release
);
    localparam int DIV_W   = $clog2(SCAN_DIV);
    localparam int COL_W   = $clog2(COLS);
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
    localparam logic [COLS-1:0]  COL_FIRST  = {1'b1, {(COLS-1){1'b0}}};

    kp_state_e         state_q, state_d;
    logic [DIV_W-1:0]  dwell_q, dwell_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [COLS-1:0]   key_col_q, key_col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              rep_first_q, rep_first_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;
    logic              key_release_q, key_release_d;

    logic [ROW_W-1:0]  hit_idx_s;
    logic [COL_W-1:0]  col_next_s;
    logic [COLS-1:0]   key_col_next_s;
    logic              row_sel_s;
    logic              rep_fire_s;
    logic              accept_s;
    logic              deb_clear_s;
    logic              deb_stable_s;
    logic              deb_done_s;

    // Highest set row bit wins when several rows are high.
    always_comb begin
        hit_idx_s = {ROW_W{1'b0}};
        for (int i = 0; i < ROWS; i++) begin
            hit_idx_s = key_row[i] ? ROW_W'(i) : hit_idx_s;
        end
    end

    assign row_sel_s      = key_row[row_q];
    assign col_next_s     = (col_q == COL_LAST) ? {COL_W{1'b0}} : col_q + COL_W'(1);
    assign key_col_next_s = {key_col_q[0], key_col_q[COLS-1:1]};
    assign rep_fire_s     = rep_first_q ? (rep_q == REP_W'(REPEAT_RATE - 1))
                                        : (rep_q == REP_W'(REPEAT_DELAY - 1));

    // Press watches the row high, release watches it low; the count carries
    // from HELD into DEB_REL so the first low clock already counts.
    assign deb_stable_s = (state_q == DEB_PRESS) ? row_sel_s : ~row_sel_s;
    assign deb_clear_s  = (state_q == SCAN) | accept_s;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (deb_clear_s),
        .stable (deb_stable_s),
        .done   (deb_done_s)
    );

    // Scan / lock state machine and output next-state logic.
    always_comb begin
        state_d       = state_q;
        dwell_d       = dwell_q;
        col_d         = col_q;
        key_col_d     = key_col_q;
        row_d         = row_q;
        rep_d         = rep_q;
        rep_first_d   = rep_first_q;
        key_code_d    = key_code_q;
        key_held_d    = key_held_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;
        accept_s      = 1'b0;
        case (state_q)
            SCAN: begin
                if (dwell_q != DWELL_LAST) begin
                    dwell_d = dwell_q + DIV_W'(1);
                end else if (|key_row) begin
                    row_d   = hit_idx_s;
                    state_d = DEB_PRESS;
                end else begin
                    dwell_d   = {DIV_W{1'b0}};
                    col_d     = col_next_s;
                    key_col_d = key_col_next_s;
                end
            end
            DEB_PRESS: begin
                if (!row_sel_s) begin
                    state_d   = SCAN;
                    dwell_d   = {DIV_W{1'b0}};
                    col_d     = col_next_s;
                    key_col_d = key_col_next_s;
                end else if (deb_done_s) begin
                    accept_s    = 1'b1;
                    state_d     = HELD;
                    key_code_d  = CODE_W'((ROWS - 1 - int'(row_q)) * COLS + int'(col_q));
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    rep_d       = {REP_W{1'b0}};
                    rep_first_d = 1'b0;
                end else begin
                    state_d = DEB_PRESS;
                end
            end
            HELD: begin
                if (!row_sel_s) begin
                    state_d = DEB_REL;
                end else if (!repeat_en) begin
                    rep_d       = {REP_W{1'b0}};
                    rep_first_d = 1'b0;
                end else if (rep_fire_s) begin
                    key_valid_d = 1'b1;
                    rep_d       = {REP_W{1'b0}};
                    rep_first_d = 1'b1;
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
            end
            DEB_REL: begin
                if (row_sel_s) begin
                    state_d = HELD;
                end else if (deb_done_s) begin
                    key_release_d = 1'b1;
                    key_held_d    = 1'b0;
                    state_d       = SCAN;
                    dwell_d       = {DIV_W{1'b0}};
                    col_d         = col_next_s;
                    key_col_d     = key_col_next_s;
                end else begin
                    state_d = DEB_REL;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= SCAN;
            dwell_q       <= {DIV_W{1'b0}};
            col_q         <= {COL_W{1'b0}};
            key_col_q     <= COL_FIRST;
            row_q         <= {ROW_W{1'b0}};
            rep_q         <= {REP_W{1'b0}};
            rep_first_q   <= 1'b0;
            key_code_q    <= {CODE_W{1'b0}};
            key_valid_q   <= 1'b0;
            key_held_q    <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            col_q         <= col_d;
            key_col_q     <= key_col_d;
            row_q         <= row_d;
            rep_q         <= rep_d;
            rep_first_q   <= rep_first_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_held_q    <= key_held_d;
            key_release_q <= key_release_d;
        end
    end

    assign key_col     = key_col_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_held    = key_held_q;
    assign key_release = key_release_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner. Drives one-hot column strobes, samples active-high row lines, debounces press and release, and emits a registered key index with single-cycle event strobes. Optional auto-repeat while a key is held. Sits between the board keypad pins and the digit-entry/display logic; the default 4x3 geometry serves the phone-style keypad.

## Interface
- `ROWS`, 4: number of row inputs; ≥ 1.
- `COLS`, 3: number of column strobes; ≥ 2.
- `SCAN_DIV`, 4: clocks each column is held before advancing; ≥ 2.
- `DEBOUNCE_CYC`, 8: consecutive stable clocks required to accept a press or a release; ≥ 1.
- `REPEAT_DELAY`, 32: held clocks from the accepted press to the first repeat.
- `REPEAT_RATE`, 16: clocks between subsequent repeats.
- `CODE_W`, $clog2(ROWS*COLS): width of the key index.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `key_row`  in  ROWS: row sense lines, active high, already synchronised.
- `repeat_en`  in  1: enables auto-repeat. Sampled every cycle.
- `key_col`  out  COLS: one-hot column strobe, active high.
- `key_code`  out  CODE_W: index of the accepted key; holds its value between events.
- `key_valid`  out  1: one-cycle pulse on each accepted press and each repeat.
- `key_held`  out  1: high from the accepted press until the accepted release.
- `key_release`  out  1: one-cycle pulse when the release is accepted.

## Operation
- Index mapping: `r` = ROWS-1-(row bit), so the top bit gives `r` = 0. `c` = COLS-1-(one-hot bit position), so the MSB strobe gives `c` = 0. `key_code` = r*COLS + c.
- Column sequence: MSB → … → LSB → MSB. A dwell counter runs 0..SCAN_DIV-1. The column advances when the counter wraps.
- Rows are sampled only on the dwell cycle where the counter equals SCAN_DIV-1. This allows settle time.
- **SCAN** state:
  - If any row is high at the sample cycle, capture (r, c) and go to DEB_PRESS.
  - The column does not advance.
  - If several rows are high, the highest row bit wins.
- **DEB_PRESS** state:
  - Column is frozen and the debounce counter counts clocks with the captured row high.
  - If the row goes low, return to SCAN and resume from the next column, with no output.
  - When the counter reaches DEBOUNCE_CYC, go to HELD. Load `key_code` and pulse `key_valid`.
- **HELD** state:
  - `key_held` = 1.
  - The repeat counter runs only while `repeat_en` = 1.
  - If `repeat_en` drops, the counter clears.
  - The first repeat `key_valid` fires REPEAT_DELAY clocks after the press pulse, then every REPEAT_RATE clocks.
  - If the captured row goes low, go to DEB_REL.
- **DEB_REL** state:
  - Counts clocks with the captured row low.
  - If the row goes high again, return to HELD with no new `key_valid`. The repeat counter keeps its value.
  - At DEBOUNCE_CYC low clocks, pulse `key_release`, clear `key_held`, go to SCAN, and resume from the next column.
- Other keys pressed while a key is locked (DEB_PRESS, HELD, DEB_REL) are ignored. Only the captured row is examined.
- `key_valid` and `key_release` are never high in the same cycle.

## Timing
- All outputs are registered.
- Reset values:
  - `key_col` = MSB one-hot (3'b100 for COLS = 3).
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0, `key_release` = 0.
  - State = SCAN, all counters = 0.
- Reset asserted mid-operation (any state) takes effect at the next edge, with the same values. No `key_release` is generated.
- Press latency: with sample at edge T and the row held high, `key_valid` is high in the cycle after edge T+DEBOUNCE_CYC+1. `key_held` rises in that same cycle.
- Release latency: with the row dropping before edge U, `key_release` is high in the cycle after edge U+DEBOUNCE_CYC.
- Repeat with `repeat_en` = 1 and the press pulse at cycle P: repeat pulses at P+REPEAT_DELAY, then P+REPEAT_DELAY+k*REPEAT_RATE.
- Worst-case scan period: COLS*SCAN_DIV clocks.

## Structure
- Shared package `keypad_pkg`:
  - State enum `{SCAN, DEB_PRESS, HELD, DEB_REL}`.
  - Symbol constants SN = 0, SA = 1, SS = 2, S0–S9 = 3–12.
  - Function `keypad_4x3_symbol(code)` maps index to symbol: 0..11 → S1, S2, S3, S4, S5, S6, S7, S8, S9, SA, S0, SS.
- One sub-module: `key_debounce`. It is a stable-count comparator parametrised by DEBOUNCE_CYC and is used for both press and release.
- Column rotation and the repeat counter stay in the top module.

## Test plan
Bench parameters: defaults (ROWS = 4, COLS = 3, SCAN_DIV = 4, DEBOUNCE_CYC = 8, REPEAT_DELAY = 32, REPEAT_RATE = 16).
- **Reset:** hold `rst_n` = 0 for 3 clocks → `key_col` = 100, all other outputs 0. Release reset → `key_col` steps 100 → 010 → 001 → 100 every 4 clocks.
- **Clean press/release:** assert `key_row[3]` while `key_col` = 010 for 40 clocks, then release → one `key_valid` with `key_code` = 1 (symbol S2). `key_held` stays high until `key_release` pulses 8 clocks after the drop.
- **Bounce rejection:** row pulses of 5 clocks high / 3 low on `key_row[0]` → no `key_valid`, and scanning continues.
- **Release bounce:** while held, drop the row for 4 clocks, then restore → no `key_release` and no extra `key_valid`.
- **Auto-repeat:** `repeat_en` = 1, hold key (r = 2, c = 2) for 100 clocks → `key_code` = 8 (S9), `key_valid` at P, P+32, P+48, P+64, P+80, P+96.
- **Priority and lock:** `key_row` = 1010 at the sample → `key_code` row index 0. Then raise `key_row[0]` while held → ignored. Reset asserted in HELD → all outputs 0 next cycle, no `key_release`.
